width_conv_fifo: RTL and testbench

Single-clock FIFO with independent write and read data widths, packing narrow write words into wide read words or splitting wide write words into narrow read words. Sits between producer and consumer datapaths of different bus widths in the same clock domain. Provides exact occupancy counts, space counts and status flags on both sides, with standard or first-word-fall-through (FWFT) read behaviour.

---
 rtl/width_conv_fifo_pkg.sv | 22 ++
 rtl/width_conv_fifo_slot_ram.sv | 36 +++
 rtl/width_conv_fifo.sv | 144 ++++++++++++++
 tb/tb_width_conv_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/width_conv_fifo_pkg.sv
// Shared constants and geometry helpers for the width-converting FIFO.
// Storage is organised in slots of the narrower port width.
package width_conv_fifo_pkg;

    localparam string MODE_STD  = "STD";
    localparam string MODE_FWFT = "FWFT";
    localparam string DIR_LSB   = "LSB";
    localparam string DIR_MSB   = "MSB";

    function automatic int unit_width(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int slot_ratio(input int width, input int unit);
        return width / unit;
    endfunction

    function automatic int slot_count(input int depth, input int width, input int unit);
        return depth * width / unit;
    endfunction

endpackage

// File: rtl/width_conv_fifo_slot_ram.sv
// Slot-granular register array: one write port covering RW consecutive slots
// and one asynchronous read port covering RR consecutive slots.
module width_conv_fifo_slot_ram #(
    parameter int U  = 16,
    parameter int N  = 64,
    parameter int RW = 1,
    parameter int RR = 4,
    parameter int AW = 6
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [RW*U-1:0]  wdata,
    input  logic [AW-1:0]    raddr,
    output logic [RR*U-1:0]  rdata
);

    logic [U-1:0] mem [N];

    // Addresses are always multiples of RW/RR, so a group never straddles the wrap.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < RW; k++) begin
                mem[waddr + AW'(k)] <= wdata[k*U +: U];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < RR; j++) begin
            rdata[j*U +: U] = mem[raddr + AW'(j)];
        end
    end

endmodule

// File: rtl/width_conv_fifo.sv
// Single-clock FIFO with independent write/read widths (pack or split),
// exact occupancy/space counts, status flags and STD or FWFT read behaviour.
module width_conv_fifo
    import width_conv_fifo_pkg::*;
#(
    parameter int    INPUT_WIDTH       = 16,
    parameter int    OUTPUT_WIDTH      = 64,
    parameter int    WR_DEPTH          = 64,
    parameter int    RD_DEPTH          = 16,
    parameter string MODE              = "FWFT",
    parameter string DIRECTION         = "LSB",
    parameter int    PROG_FULL_THRESH  = 10,
    parameter int    PROG_EMPTY_THRESH = 10
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [INPUT_WIDTH-1:0]            din,
    output logic                              wr_ready,
    output logic                              wr_ack,
    output logic                              overflow,
    input  logic                              rd_en,
    output logic [OUTPUT_WIDTH-1:0]           dout,
    output logic                              valid,
    output logic                              underflow,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic                              prog_full,
    output logic                              prog_empty,
    output logic [$clog2(WR_DEPTH):0]         wr_data_count,
    output logic [$clog2(WR_DEPTH):0]         wr_data_space,
    output logic [$clog2(RD_DEPTH):0]         rd_data_count,
    output logic [$clog2(RD_DEPTH):0]         rd_data_space
);

    localparam int U    = unit_width(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int RW   = slot_ratio(INPUT_WIDTH, U);
    localparam int RR   = slot_ratio(OUTPUT_WIDTH, U);
    localparam int N    = slot_count(WR_DEPTH, INPUT_WIDTH, U);
    localparam int AW   = $clog2(N);
    localparam int PW   = AW + 1;
    localparam int FW   = PW + 1;
    localparam int WCW  = $clog2(WR_DEPTH) + 1;
    localparam int RCW  = $clog2(RD_DEPTH) + 1;
    localparam int RWS  = $clog2(RW);
    localparam int RRS  = $clog2(RR);
    localparam bit IS_FWFT = (MODE == MODE_FWFT);
    localparam bit IS_MSB  = (DIRECTION == DIR_MSB);

    logic [PW-1:0]           wptr;
    logic [PW-1:0]           rptr;
    logic [PW-1:0]           used;
    logic [FW-1:0]           free_slots;
    logic                    do_wr;
    logic                    do_rd;
    logic [INPUT_WIDTH-1:0]  wdata;
    logic [OUTPUT_WIDTH-1:0] rdata;
    logic [OUTPUT_WIDTH-1:0] rword;

    assign used          = wptr - rptr;
    assign free_slots    = FW'(N) - {1'b0, used};
    assign wr_data_space = WCW'(free_slots >> RWS);
    assign wr_data_count = WCW'(WR_DEPTH) - wr_data_space;
    assign rd_data_count = RCW'(used >> RRS);
    assign rd_data_space = RCW'(RD_DEPTH) - rd_data_count;

    assign full         = (wr_data_space == '0);
    assign empty        = (rd_data_count == '0);
    assign almost_full  = (wr_data_space == WCW'(1));
    assign almost_empty = (rd_data_count == RCW'(1));
    assign prog_full    = (int'(wr_data_count) >= PROG_FULL_THRESH);
    assign prog_empty   = (int'(rd_data_count) <= PROG_EMPTY_THRESH);
    assign wr_ready     = ~full;

    // Both requests are judged against start-of-cycle flags.
    assign do_wr = wr_en & ~full & ~reset;
    assign do_rd = rd_en & ~empty & ~reset;

    // Slots are stored in arrival order; DIRECTION only changes slice mapping.
    always_comb begin
        wdata = '0;
        for (int k = 0; k < RW; k++) begin
            wdata[k*U +: U] = IS_MSB ? din[(RW-1-k)*U +: U] : din[k*U +: U];
        end
    end

    always_comb begin
        rword = '0;
        for (int j = 0; j < RR; j++) begin
            rword[j*U +: U] = IS_MSB ? rdata[(RR-1-j)*U +: U] : rdata[j*U +: U];
        end
    end

    width_conv_fifo_slot_ram #(
        .U  (U),
        .N  (N),
        .RW (RW),
        .RR (RR),
        .AW (AW)
    ) u_ram (
        .clock (clock),
        .we    (do_wr),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wptr <= wptr + PW'(RW);
            if (do_rd) rptr <= rptr + PW'(RR);
            wr_ack    <= do_wr;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    generate
        if (IS_FWFT) begin : g_fwft
            assign dout  = empty ? '0 : rword;
            assign valid = ~empty;
        end else begin : g_std
            always_ff @(posedge clock) begin
                if (reset) begin
                    dout  <= '0;
                    valid <= 1'b0;
                end else begin
                    valid <= do_rd;
                    if (do_rd) dout <= rword;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_width_conv_fifo.sv
// Scoreboard bench: a 16->64 LSB FWFT, a 16->64 LSB STD and a 64->16 MSB FWFT instance.
module tb_width_conv_fifo;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: 16->64 LSB FWFT
    logic a_wr_en, a_rd_en;
    logic [15:0] a_din;
    logic [63:0] a_dout;
    logic a_wr_ready, a_wr_ack, a_overflow, a_valid, a_underflow;
    logic a_full, a_empty, a_af, a_ae, a_pf, a_pe;
    logic [6:0] a_wcnt, a_wspc;
    logic [4:0] a_rcnt, a_rspc;

    // Instance B: 16->64 LSB STD
    logic b_wr_en, b_rd_en;
    logic [15:0] b_din;
    logic [63:0] b_dout;
    logic b_wr_ready, b_wr_ack, b_overflow, b_valid, b_underflow;
    logic b_full, b_empty, b_af, b_ae, b_pf, b_pe;
    logic [6:0] b_wcnt, b_wspc;
    logic [4:0] b_rcnt, b_rspc;

    // Instance C: 64->16 MSB FWFT
    logic c_wr_en, c_rd_en;
    logic [63:0] c_din;
    logic [15:0] c_dout;
    logic c_wr_ready, c_wr_ack, c_overflow, c_valid, c_underflow;
    logic c_full, c_empty, c_af, c_ae, c_pf, c_pe;
    logic [4:0] c_wcnt, c_wspc;
    logic [6:0] c_rcnt, c_rspc;

    width_conv_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(64), .WR_DEPTH(64), .RD_DEPTH(16),
                      .MODE("FWFT"), .DIRECTION("LSB")) u_a (
        .clock(clock), .reset(reset), .wr_en(a_wr_en), .din(a_din), .wr_ready(a_wr_ready),
        .wr_ack(a_wr_ack), .overflow(a_overflow), .rd_en(a_rd_en), .dout(a_dout),
        .valid(a_valid), .underflow(a_underflow), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .prog_full(a_pf), .prog_empty(a_pe),
        .wr_data_count(a_wcnt), .wr_data_space(a_wspc), .rd_data_count(a_rcnt),
        .rd_data_space(a_rspc));

    width_conv_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(64), .WR_DEPTH(64), .RD_DEPTH(16),
                      .MODE("STD"), .DIRECTION("LSB")) u_b (
        .clock(clock), .reset(reset), .wr_en(b_wr_en), .din(b_din), .wr_ready(b_wr_ready),
        .wr_ack(b_wr_ack), .overflow(b_overflow), .rd_en(b_rd_en), .dout(b_dout),
        .valid(b_valid), .underflow(b_underflow), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .prog_full(b_pf), .prog_empty(b_pe),
        .wr_data_count(b_wcnt), .wr_data_space(b_wspc), .rd_data_count(b_rcnt),
        .rd_data_space(b_rspc));

    width_conv_fifo #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(16), .WR_DEPTH(16), .RD_DEPTH(64),
                      .MODE("FWFT"), .DIRECTION("MSB")) u_c (
        .clock(clock), .reset(reset), .wr_en(c_wr_en), .din(c_din), .wr_ready(c_wr_ready),
        .wr_ack(c_wr_ack), .overflow(c_overflow), .rd_en(c_rd_en), .dout(c_dout),
        .valid(c_valid), .underflow(c_underflow), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .prog_full(c_pf), .prog_empty(c_pe),
        .wr_data_count(c_wcnt), .wr_data_space(c_wspc), .rd_data_count(c_rcnt),
        .rd_data_space(c_rspc));

    // Scoreboards and the write-side model for instance A
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [15:0] qc[$];
    logic [63:0] acc_a;
    int          nacc_a;
    int          used_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_a_write(input logic [15:0] d);
        if (used_a < 64) begin
            acc_a[nacc_a*16 +: 16] = d;
            nacc_a++;
            used_a++;
            if (nacc_a == 4) begin
                qa.push_back(acc_a);
                nacc_a = 0;
            end
        end
    endtask

    task automatic a_write(input logic [15:0] d);
        a_wr_en = 1'b1;
        a_din   = d;
        model_a_write(d);
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input string tag);
        if (qa.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(a_valid), 64'd0);
        end else begin
            chk(tag, a_dout, qa[0]);
            a_rd_en = 1'b1;
            tick();
            a_rd_en = 1'b0;
            void'(qa.pop_front());
            used_a -= 4;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_wr_en = 0; a_rd_en = 0; a_din = '0;
        b_wr_en = 0; b_rd_en = 0; b_din = '0;
        c_wr_en = 0; c_rd_en = 0; c_din = '0;
        acc_a = '0; nacc_a = 0; used_a = 0;
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;

        chk("rst_empty",     64'(a_empty),    64'd1);
        chk("rst_ae",        64'(a_ae),       64'd0);
        chk("rst_pe",        64'(a_pe),       64'd1);
        chk("rst_full",      64'(a_full),     64'd0);
        chk("rst_af",        64'(a_af),       64'd0);
        chk("rst_pf",        64'(a_pf),       64'd0);
        chk("rst_wcnt",      64'(a_wcnt),     64'd0);
        chk("rst_wspc",      64'(a_wspc),     64'd64);
        chk("rst_rcnt",      64'(a_rcnt),     64'd0);
        chk("rst_rspc",      64'(a_rspc),     64'd16);
        chk("rst_dout",      a_dout,          64'd0);
        chk("rst_valid",     64'(a_valid),    64'd0);
        chk("rst_ack",       64'(a_wr_ack),   64'd0);
        chk("rst_ovf",       64'(a_overflow), 64'd0);
        chk("rst_unf",       64'(a_underflow),64'd0);
        chk("rst_ready",     64'(a_wr_ready), 64'd1);
        chk("rst_b_valid",   64'(b_valid),    64'd0);
        chk("rst_c_wspc",    64'(c_wspc),     64'd16);

        // Packing 16->64 LSB, FWFT
        a_write(16'h0123);
        a_write(16'h0224);
        a_write(16'h0325);
        chk("pack_valid_early", 64'(a_valid), 64'd0);
        a_write(16'h0426);
        chk("pack_ack",   64'(a_wr_ack), 64'd1);
        chk("pack_valid", 64'(a_valid),  64'd1);
        chk("pack_dout",  a_dout,        64'h0426_0325_0224_0123);
        chk("pack_rcnt",  64'(a_rcnt),   64'd1);
        chk("pack_wcnt",  64'(a_wcnt),   64'd4);
        chk("pack_ae",    64'(a_ae),     64'd1);
        a_read("pack_rd");
        chk("pack_empty", 64'(a_empty),  64'd1);
        chk("pack_ack_clr", 64'(a_wr_ack), 64'd0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 64; i++) begin
            a_write(16'($urandom));
            if (i == 8)  chk("fill_pf_below", 64'(a_pf), 64'd0);
            if (i == 9)  chk("fill_pf_at",    64'(a_pf), 64'd1);
            if (i == 62) begin
                chk("fill_af_63",   64'(a_af),   64'd1);
                chk("fill_full_63", 64'(a_full), 64'd0);
            end
        end
        chk("fill_full",  64'(a_full),     64'd1);
        chk("fill_af",    64'(a_af),       64'd0);
        chk("fill_wspc",  64'(a_wspc),     64'd0);
        chk("fill_rcnt",  64'(a_rcnt),     64'd16);
        chk("fill_ready", 64'(a_wr_ready), 64'd0);
        chk("fill_pe",    64'(a_pe),       64'd0);
        a_wr_en = 1'b1;
        a_din   = 16'hFFFF;
        tick();
        a_wr_en = 1'b0;
        chk("ovf_pulse", 64'(a_overflow), 64'd1);
        chk("ovf_ack",   64'(a_wr_ack),   64'd0);
        chk("ovf_wcnt",  64'(a_wcnt),     64'd64);
        tick();
        chk("ovf_clear", 64'(a_overflow), 64'd0);
        for (int i = 0; i < 16; i++) a_read("drain");
        chk("drain_empty", 64'(a_empty), 64'd1);
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        chk("a_unf_pulse", 64'(a_underflow), 64'd1);

        // Simultaneous write and read
        for (int i = 0; i < 8; i++) a_write(16'h1000 + 16'(i));
        chk("sim_dout", a_dout, qa[0]);
        void'(qa.pop_front());
        used_a -= 4;
        a_wr_en = 1'b1;
        a_rd_en = 1'b1;
        a_din   = 16'h2000;
        model_a_write(16'h2000);
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        chk("sim_wcnt", 64'(a_wcnt), 64'(used_a));
        chk("sim_wcnt_k", 64'(a_wcnt), 64'd5);
        chk("sim_rcnt", 64'(a_rcnt), 64'd1);
        a_read("sim_rd");

        // Reset mid-operation with requests held high
        for (int i = 0; i < 19; i++) a_write(16'h3000 + 16'(i));
        chk("pre_rst_wcnt", 64'(a_wcnt), 64'd20);
        reset   = 1'b1;
        a_wr_en = 1'b1;
        a_rd_en = 1'b1;
        a_din   = 16'hBEEF;
        tick();
        reset   = 1'b0;
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        qa.delete();
        nacc_a = 0;
        used_a = 0;
        chk("mrst_empty", 64'(a_empty), 64'd1);
        chk("mrst_wcnt",  64'(a_wcnt),  64'd0);
        chk("mrst_rcnt",  64'(a_rcnt),  64'd0);
        chk("mrst_dout",  a_dout,       64'd0);
        chk("mrst_valid", 64'(a_valid), 64'd0);
        chk("mrst_ovf",   64'(a_overflow), 64'd0);
        for (int i = 0; i < 4; i++) a_write(16'h4400 + 16'(i));
        a_read("post_rst_rd");

        // STD read mode
        for (int i = 0; i < 4; i++) begin
            b_wr_en = 1'b1;
            b_din   = 16'hA000 + 16'(i);
            tick();
        end
        b_wr_en = 1'b0;
        qb.push_back(64'hA003_A002_A001_A000);
        chk("std_valid_idle", 64'(b_valid), 64'd0);
        chk("std_empty",      64'(b_empty), 64'd0);
        chk("std_dout_idle",  b_dout,       64'd0);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        chk("std_valid", 64'(b_valid), 64'd1);
        chk("std_dout",  b_dout,       qb[0]);
        tick();
        chk("std_valid_drop", 64'(b_valid), 64'd0);
        chk("std_dout_hold",  b_dout,       qb[0]);
        void'(qb.pop_front());
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        chk("std_unf",       64'(b_underflow), 64'd1);
        chk("std_unf_valid", 64'(b_valid),     64'd0);
        tick();
        chk("std_unf_clear", 64'(b_underflow), 64'd0);

        // Splitting 64->16 MSB
        c_wr_en = 1'b1;
        c_din   = 64'h0426_0325_0224_0123;
        for (int k = 3; k >= 0; k--) qc.push_back(c_din[k*16 +: 16]);
        tick();
        c_wr_en = 1'b0;
        chk("split_wcnt", 64'(c_wcnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("split_rcnt",  64'(c_rcnt), 64'(4 - i));
            chk("split_valid", 64'(c_valid), 64'd1);
            chk("split_dout",  64'(c_dout), 64'(qc[0]));
            c_rd_en = 1'b1;
            tick();
            c_rd_en = 1'b0;
            void'(qc.pop_front());
        end
        chk("split_rcnt_end", 64'(c_rcnt),  64'd0);
        chk("split_empty",    64'(c_empty), 64'd1);
        chk("split_wcnt_end", 64'(c_wcnt),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
